// File: rtl/board_ctrl_debounce.sv
// board_ctrl_debounce
//   Board-support control for the bootloader top level. Synchronises and
//   debounces the button bank, stretches the user reset, detects a long press
//   of the boot button and drives the status LEDs with a heartbeat.
//
// Ports
//   clk_48mhz   : system clock (48 MHz USB clock)
//   reset       : synchronous, active-high
//   btn_raw     : asynchronous board buttons
//   btn_db      : debounced, polarity-corrected levels (1 = pressed)
//   btn_press   : one-cycle pulse after each debounced 0->1
//   btn_release : one-cycle pulse after each debounced 1->0
//   user_reset  : stretched reset to the bootloader core
//   boot_req    : one-cycle pulse on a long press of BOOT_BTN
//   wifi_gpio0  : mirrors btn_db[BOOT_BTN]
//   led_core    : status LED from the bootloader core
//   boot_in     : boot strobe from the bootloader core
//   led         : status LEDs (registered)
module board_ctrl_debounce #(
  parameter int                 NUM_BTN           = 7,
  parameter logic [NUM_BTN-1:0] BTN_INVERT        = 7'b0000001,
  parameter int                 DEBOUNCE_CYCLES   = 48000,
  parameter int                 RESET_BTN         = 1,
  parameter int                 BOOT_BTN          = 0,
  parameter int                 RESET_HOLD_CYCLES = 16,
  parameter int                 LONG_PRESS_CYCLES = 96000000,
  parameter int                 NUM_LED           = 8,
  parameter int                 BLINK_HALF_CYCLES = 12000000
) (
  input  logic               clk_48mhz,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_db,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               user_reset,
  output logic               boot_req,
  output logic               wifi_gpio0,
  input  logic               led_core,
  input  logic               boot_in,
  output logic [NUM_LED-1:0] led
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF_CYCLES + 1);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RESET_HOLD_CYCLES);
  localparam logic [LW-1:0] LP_MAX    = LW'(LONG_PRESS_CYCLES);
  localparam logic [LW-1:0] LP_LAST   = LW'(LONG_PRESS_CYCLES - 1);
  localparam logic [BW-1:0] BL_LAST   = BW'(BLINK_HALF_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Per-button synchroniser + debounce + edge pulses
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic          meta, sync_q, sync;
    logic          db, db_q, press, rel;
    logic [CW-1:0] cnt;

    // Flops reset to the inversion value so the corrected level is 0.
    assign sync = sync_q ^ BTN_INVERT[i];

    always_ff @(posedge clk_48mhz) begin
      if (reset) begin
        meta   <= BTN_INVERT[i];
        sync_q <= BTN_INVERT[i];
        cnt    <= '0;
        db     <= 1'b0;
        db_q   <= 1'b0;
        press  <= 1'b0;
        rel    <= 1'b0;
      end else begin
        meta   <= btn_raw[i];
        sync_q <= meta;
        // Any cycle where the input agrees with the accepted level restarts
        // the count, so only an unbroken run of DEBOUNCE_CYCLES toggles.
        if (sync == db) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          cnt <= '0;
          db  <= ~db;
        end else begin
          cnt <= cnt + 1'b1;
        end
        db_q  <= db;
        press <= db & ~db_q;
        rel   <= ~db & db_q;
      end
    end

    assign btn_db[i]      = db;
    assign btn_press[i]   = press;
    assign btn_release[i] = rel;
  end

  assign wifi_gpio0 = btn_db[BOOT_BTN];

  // ---------------------------------------------------------------------
  // Stretched user reset: held while the source is active, then counts
  // down. A re-press reloads before the count expires, so no gap.
  // ---------------------------------------------------------------------
  logic [HW-1:0] hold;

  always_ff @(posedge clk_48mhz) begin
    if (reset || btn_db[RESET_BTN]) hold <= HOLD_LOAD;
    else if (hold != '0)            hold <= hold - 1'b1;
  end

  assign user_reset = reset | btn_db[RESET_BTN] | (hold != '0);

  // ---------------------------------------------------------------------
  // Long press: counter saturates at the threshold so the pulse fires
  // once per press; releasing clears it.
  // ---------------------------------------------------------------------
  logic [LW-1:0] lp_cnt;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      lp_cnt   <= '0;
      boot_req <= 1'b0;
    end else begin
      boot_req <= btn_db[BOOT_BTN] && (lp_cnt == LP_LAST);
      if (!btn_db[BOOT_BTN])  lp_cnt <= '0;
      else if (lp_cnt != LP_MAX) lp_cnt <= lp_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Heartbeat, boot latch and LED register
  // ---------------------------------------------------------------------
  logic [BW-1:0]      blink_cnt;
  logic               heartbeat;
  logic               boot_seen;
  logic [NUM_LED-1:0] led_next;

  always_comb begin
    led_next              = '0;
    led_next[0]           = led_core;
    led_next[1]           = heartbeat;
    led_next[NUM_LED-3]   = boot_seen;
    led_next[NUM_LED-2]   = user_reset;
    led_next[NUM_LED-1]   = btn_db[BOOT_BTN];
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      blink_cnt <= '0;
      heartbeat <= 1'b0;
      boot_seen <= 1'b0;
      led       <= '0;
    end else begin
      if (blink_cnt == BL_LAST) begin
        blink_cnt <= '0;
        heartbeat <= ~heartbeat;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      // Sticky until the next reset.
      if (boot_in) boot_seen <= 1'b1;
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_board_ctrl_debounce.sv
// tb_board_ctrl_debounce
//   Directed vectors against board_ctrl_debounce with small parameters.
//   Stimulus pushes expected pulse events and level samples (with the cycle
//   they are due) into queues; the monitor pops and compares them.
module tb_board_ctrl_debounce;

  localparam int NB    = 7;
  localparam int NL    = 8;
  localparam int LIMIT = 3000;

  logic          clk_48mhz = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw, btn_db, btn_press, btn_release;
  logic          user_reset, boot_req, wifi_gpio0, led_core, boot_in;
  logic [NL-1:0] led;

  board_ctrl_debounce #(
    .NUM_BTN(NB), .BTN_INVERT(7'b0000001), .DEBOUNCE_CYCLES(4),
    .RESET_BTN(1), .BOOT_BTN(0), .RESET_HOLD_CYCLES(16),
    .LONG_PRESS_CYCLES(100), .NUM_LED(NL), .BLINK_HALF_CYCLES(10)
  ) dut (
    .clk_48mhz(clk_48mhz), .reset(reset), .btn_raw(btn_raw),
    .btn_db(btn_db), .btn_press(btn_press), .btn_release(btn_release),
    .user_reset(user_reset), .boot_req(boot_req), .wifi_gpio0(wifi_gpio0),
    .led_core(led_core), .boot_in(boot_in), .led(led)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  int cyc = 0;
  always @(posedge clk_48mhz) cyc <= cyc + 1;

  typedef enum int {EV_PRESS, EV_REL, EV_BOOT, EV_URFALL} ev_kind_e;
  typedef enum int {S_DB, S_UR, S_BOOT, S_WIFI, S_LED, S_PRESS, S_REL} sel_e;
  typedef struct { int cyc; ev_kind_e kind; logic [31:0] val; } ev_t;
  typedef struct { int cyc; sel_e sel; logic [31:0] mask; logic [31:0] exp; string name; } lv_t;

  ev_t evq[$];
  lv_t lvq[$];
  bit  done = 1'b0;
  int  vectors = 0;
  int  miscompares = 0;

  function automatic logic [31:0] sig(input sel_e s);
    case (s)
      S_DB:    return 32'(btn_db);
      S_UR:    return {31'b0, user_reset};
      S_BOOT:  return {31'b0, boot_req};
      S_WIFI:  return {31'b0, wifi_gpio0};
      S_LED:   return 32'(led);
      S_PRESS: return 32'(btn_press);
      S_REL:   return 32'(btn_release);
      default: return 32'b0;
    endcase
  endfunction

  task automatic lvl(input int c, input sel_e s, input logic [31:0] m,
                     input logic [31:0] x, input string n);
    lvq.push_back('{c, s, m, x, n});
  endtask

  task automatic ev(input int c, input ev_kind_e k, input logic [31:0] v);
    evq.push_back('{c, k, v});
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk_48mhz);
  endtask

  // ----------------------------------------------------------------------
  // Monitor / scoreboard
  // ----------------------------------------------------------------------
  task automatic take_event(input ev_kind_e k, input logic [31:0] v);
    ev_t e;
    vectors++;
    if (evq.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind=%0d val=%h at cyc %0d, required none", k, v, cyc);
    end else begin
      e = evq.pop_front();
      if (e.kind != k || e.val != v || e.cyc != cyc) begin
        miscompares++;
        $display("FAIL event: got kind=%0d val=%h cyc=%0d, required kind=%0d val=%h cyc=%0d",
                 k, v, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  initial begin : monitor
    logic        ur_prev;
    logic [31:0] got;
    ur_prev = 1'b1;
    forever begin
      @(negedge clk_48mhz);
      if (btn_press   != '0) take_event(EV_PRESS, 32'(btn_press));
      if (btn_release != '0) take_event(EV_REL,   32'(btn_release));
      if (boot_req)          take_event(EV_BOOT,  32'd1);
      if (ur_prev && !user_reset) take_event(EV_URFALL, 32'd1);
      ur_prev = user_reset;

      for (int i = lvq.size() - 1; i >= 0; i--) begin
        if (lvq[i].cyc == cyc) begin
          got = sig(lvq[i].sel) & lvq[i].mask;
          vectors++;
          if (got !== (lvq[i].exp & lvq[i].mask)) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h, required %h",
                     lvq[i].name, cyc, got, lvq[i].exp & lvq[i].mask);
          end
          lvq.delete(i);
        end
      end

      if (done || cyc > LIMIT) begin
        if (!done) begin
          vectors++; miscompares++;
          $display("FAIL timeout: got cyc %0d, required finish by %0d", cyc, LIMIT);
        end
        foreach (evq[i]) begin
          vectors++; miscompares++;
          $display("FAIL missing_event: got none, required kind=%0d val=%h cyc=%0d",
                   evq[i].kind, evq[i].val, evq[i].cyc);
        end
        foreach (lvq[i]) begin
          vectors++; miscompares++;
          $display("FAIL %s: got unchecked, required check at cyc %0d", lvq[i].name, lvq[i].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

  // ----------------------------------------------------------------------
  // Stimulus (inputs change on the negedge; cyc = posedges so far)
  // ----------------------------------------------------------------------
  initial begin : stim
    int t0, r, t, r2;
    reset = 1'b1; btn_raw = 7'b0000001; led_core = 1'b0; boot_in = 1'b0;
    repeat (3) @(negedge clk_48mhz);

    // Reset state
    t0 = cyc;
    lvl(t0+1, S_DB,    '1, 0, "rst_btn_db");
    lvl(t0+1, S_UR,    1,  1, "rst_user_reset");
    lvl(t0+1, S_BOOT,  1,  0, "rst_boot_req");
    lvl(t0+1, S_WIFI,  1,  0, "rst_wifi");
    lvl(t0+1, S_LED,   '1, 0, "rst_led");
    lvl(t0+1, S_PRESS, '1, 0, "rst_press");
    lvl(t0+1, S_REL,   '1, 0, "rst_release");
    to_cyc(t0+2);
    r = cyc; reset = 1'b0;
    lvl(r+15, S_UR, 1, 1, "ur_stretch_last");
    ev(r+16, EV_URFALL, 1);

    // Clean press/release on bit 3
    to_cyc(r+20); t = cyc;
    btn_raw[3] = 1'b1;
    lvl(t+5, S_DB, '1, 0,     "db3_before");
    lvl(t+6, S_DB, '1, 32'h8, "db3_set");
    ev(t+7, EV_PRESS, 32'h8);
    to_cyc(t+12); btn_raw[3] = 1'b0;
    lvl(t+17, S_DB, '1, 32'h8, "db3_held");
    lvl(t+18, S_DB, '1, 0,     "db3_clr");
    ev(t+19, EV_REL, 32'h8);

    // 3-cycle glitch rejected, 4-cycle pulse accepted on bit 2
    to_cyc(t+25); t = cyc;
    btn_raw[2] = 1'b1;
    to_cyc(t+3); btn_raw[2] = 1'b0;
    lvl(t+8, S_DB, '1, 0, "glitch3_db");
    to_cyc(t+15); t = cyc;
    btn_raw[2] = 1'b1;
    to_cyc(t+4); btn_raw[2] = 1'b0;
    lvl(t+6,  S_DB, '1, 32'h4, "glitch4_db");
    lvl(t+10, S_DB, '1, 0,     "glitch4_clr");
    ev(t+7,  EV_PRESS, 32'h4);
    ev(t+11, EV_REL,   32'h4);

    // Active-low boot button (bit 0)
    to_cyc(t+15); t = cyc;
    btn_raw[0] = 1'b0;
    lvl(t+5,  S_WIFI, 1,     0,     "wifi_idle");
    lvl(t+6,  S_DB,   '1,    32'h1, "inv_db0");
    lvl(t+6,  S_WIFI, 1,     1,     "wifi_follow");
    lvl(t+6,  S_LED,  32'h80, 0,    "led7_lag");
    lvl(t+7,  S_LED,  32'h80, 32'h80, "led7_set");
    ev(t+7, EV_PRESS, 32'h1);
    to_cyc(t+10); btn_raw[0] = 1'b1;
    lvl(t+17, S_LED, 32'h80, 0, "led7_clr");
    ev(t+17, EV_REL, 32'h1);

    // Reset button stretch and re-press inside the hold window
    to_cyc(t+25); t = cyc;
    btn_raw[1] = 1'b1;
    lvl(t+5, S_UR, 1, 0, "ur_idle");
    lvl(t+6, S_UR, 1, 1, "ur_btn");
    ev(t+7, EV_PRESS, 32'h2);
    to_cyc(t+10); btn_raw[1] = 1'b0;
    ev(t+17, EV_REL, 32'h2);
    to_cyc(t+18); btn_raw[1] = 1'b1;
    lvl(t+23, S_UR, 1, 1, "ur_hold_window");
    ev(t+25, EV_PRESS, 32'h2);
    to_cyc(t+28); btn_raw[1] = 1'b0;
    ev(t+35, EV_REL, 32'h2);
    lvl(t+49, S_UR, 1, 1, "ur_final_hold");
    ev(t+50, EV_URFALL, 1);

    // Long press: 99 debounced cycles -> nothing; 300 -> one pulse
    to_cyc(t+55); t = cyc;
    btn_raw[0] = 1'b0;
    ev(t+7, EV_PRESS, 32'h1);
    to_cyc(t+99); btn_raw[0] = 1'b1;
    lvl(t+104, S_DB, '1, 32'h1, "lp99_db");
    lvl(t+105, S_BOOT, 1, 0, "lp99_no_boot");
    ev(t+106, EV_REL, 32'h1);
    to_cyc(t+115); t = cyc;
    btn_raw[0] = 1'b0;
    ev(t+7, EV_PRESS, 32'h1);
    ev(t+106, EV_BOOT, 1);
    lvl(t+105, S_BOOT, 1, 0, "lp_pre");
    lvl(t+107, S_BOOT, 1, 0, "lp_once");
    to_cyc(t+300); btn_raw[0] = 1'b1;
    ev(t+307, EV_REL, 32'h1);

    // LEDs: heartbeat phase from reset release, led_core lag, boot latch
    to_cyc(t+315); t = cyc;
    led_core = 1'b1;
    for (int k = 1; k <= 25; k++)
      lvl(t+k, S_LED, 32'h2, (((t+k-r-1)/10) % 2 != 0) ? 32'h2 : 32'h0, "heartbeat");
    lvl(t+1,  S_LED, 32'h1,  32'h1,  "led0_on");
    lvl(t+3,  S_LED, 32'h1,  32'h1,  "led0_hold");
    lvl(t+4,  S_LED, 32'h1,  0,      "led0_off");
    lvl(t+6,  S_LED, 32'h20, 0,      "led5_before");
    lvl(t+7,  S_LED, 32'h20, 32'h20, "led5_latched");
    lvl(t+30, S_LED, 32'h20, 32'h20, "led5_sticky");
    lvl(t+32, S_LED, '1,     0,      "led_in_reset");
    lvl(t+32, S_UR,  1,      1,      "ur_in_reset");
    to_cyc(t+3); led_core = 1'b0;
    to_cyc(t+5); boot_in = 1'b1;
    to_cyc(t+6); boot_in = 1'b0;
    to_cyc(t+31); reset = 1'b1;
    to_cyc(t+33); reset = 1'b0;
    r2 = cyc;
    lvl(r2+15, S_UR,  1,      1, "ur_stretch2_last");
    lvl(r2+17, S_LED, 32'h20, 0, "led5_cleared");
    ev(r2+16, EV_URFALL, 1);
    to_cyc(r2+25);
    done = 1'b1;
  end

endmodule
